// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if: control and data bundle for the lfsr_gen generator.
// Master drives step/load/seed; slave (the generator) returns state and flags.
interface lfsr_gen_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed_in;
    logic             out;
    logic [WIDTH-1:0] q;
    logic             wrap;
    logic [WIDTH-1:0] period;
    logic             lockup;

    modport master (
        output en, load, seed_in,
        input  out, q, wrap, period, lockup
    );

    modport slave (
        input  en, load, seed_in,
        output out, q, wrap, period, lockup
    );
endinterface

// File: rtl/lfsr_gen.sv
// lfsr_gen: Fibonacci LFSR (WIDTH 3..16) with seed load and period measure.
// Optional macro LFSR_LOCKUP_RECOVER_EN: replace a zero seed with SEED.
module lfsr_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = '1,
    parameter logic [WIDTH-1:0] TAPS  = '0
) (
    input  logic       clk,
    input  logic       reset_n,
    lfsr_gen_if.slave  bus
);

    function automatic logic [15:0] default_mask(input int w);
        logic [15:0] m;
        m = '0;
        case (w)
            3:       m = 16'h0003;
            4:       m = 16'h0003;
            5:       m = 16'h0005;
            6:       m = 16'h0003;
            7:       m = 16'h0003;
            8:       m = 16'h001D;
            9:       m = 16'h0011;
            10:      m = 16'h0009;
            11:      m = 16'h0005;
            12:      m = 16'h0053;
            13:      m = 16'h001B;
            14:      m = 16'h0443;
            15:      m = 16'h0003;
            16:      m = 16'h100B;
            default: m = '0;
        endcase
        return m;
    endfunction

    localparam logic [15:0]      TABLE = default_mask(WIDTH);
    localparam logic [WIDTH-1:0] MASK  =
        (TAPS != '0) ? TAPS : TABLE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be in 3..16");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_gen: SEED must be nonzero");
    end
    if (TAPS != '0 && !TAPS[0]) begin : g_bad_taps
        $error("lfsr_gen: TAPS override must have bit 0 set");
    end

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             out_q, out_d;
    logic             wrap_q, wrap_d;
    logic             fb;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] seed_eff;

    assign fb   = ^(state_q & MASK);
    assign step = {fb, state_q[WIDTH-1:1]};

`ifdef LFSR_LOCKUP_RECOVER_EN
    logic seed_zero;
    logic lockup_q, lockup_d;

    assign seed_zero = (bus.seed_in == '0);
    assign seed_eff  = seed_zero ? SEED : bus.seed_in;
    assign lockup_d  = bus.load & seed_zero;

    // Flag a corrected zero load for one cycle, aligned with new q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lockup_q <= 1'b0;
        end else begin
            lockup_q <= lockup_d;
        end
    end

    assign bus.lockup = lockup_q;
`else
    // A zero seed is taken as-is; the LFSR then sits at zero.
    assign seed_eff   = bus.seed_in;
    assign bus.lockup = 1'b0;
`endif

    // Next state: load beats step; a step that lands on sreg closes a period.
    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        out_d    = out_q;
        wrap_d   = 1'b0;
        if (bus.load) begin
            state_d = seed_eff;
            sreg_d  = seed_eff;
            cnt_d   = '0;
            out_d   = state_q[0];
        end else if (bus.en) begin
            state_d = step;
            out_d   = state_q[0];
            if (step == sreg_q) begin
                wrap_d   = 1'b1;
                period_d = cnt_q + ONE;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    // State, seed, counter and flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= SEED;
            sreg_q   <= SEED;
            cnt_q    <= '0;
            period_q <= '0;
            out_q    <= 1'b1;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            out_q    <= out_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.q      = state_q;
    assign bus.out    = out_q;
    assign bus.wrap   = wrap_q;
    assign bus.period = period_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: scoreboard bench over four widths (3, 5, 8, 16).
// Honours LFSR_LOCKUP_RECOVER_EN for the zero-seed expectations.
module tb_lfsr_gen;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    lfsr_gen_if #(.WIDTH(3))  b0 ();
    lfsr_gen_if #(.WIDTH(5))  b1 ();
    lfsr_gen_if #(.WIDTH(8))  b2 ();
    lfsr_gen_if #(.WIDTH(16)) b3 ();

    lfsr_gen #(.WIDTH(3))  u0 (.clk(clk), .reset_n(reset_n), .bus(b0.slave));
    lfsr_gen #(.WIDTH(5))  u1 (.clk(clk), .reset_n(reset_n), .bus(b1.slave));
    lfsr_gen #(.WIDTH(8))  u2 (.clk(clk), .reset_n(reset_n), .bus(b2.slave));
    lfsr_gen #(.WIDTH(16)) u3 (.clk(clk), .reset_n(reset_n), .bus(b3.slave));

    typedef struct {
        int          inst;
        logic [15:0] q;
        logic        out;
        logic        wrap;
        logic [15:0] period;
        logic        lockup;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   nvec = 0;
    int   nbad = 0;

    int          W[4]   = '{3, 5, 8, 16};
    logic [15:0] MSK[4] = '{16'h0003, 16'h0005, 16'h001D, 16'h100B};

    logic [15:0] mq[4], msr[4], mcnt[4], mper[4];
    logic        mout[4], mwrap[4], mlk[4];

    function automatic logic [15:0] wmask(input int i);
        return 16'hFFFF >> (16 - W[i]);
    endfunction

    task automatic get(input int i, output logic [15:0] gq, output logic go,
                       output logic gw, output logic [15:0] gp,
                       output logic gl);
        case (i)
            0: begin
                gq = 16'(b0.q); go = b0.out; gw = b0.wrap;
                gp = 16'(b0.period); gl = b0.lockup;
            end
            1: begin
                gq = 16'(b1.q); go = b1.out; gw = b1.wrap;
                gp = 16'(b1.period); gl = b1.lockup;
            end
            2: begin
                gq = 16'(b2.q); go = b2.out; gw = b2.wrap;
                gp = 16'(b2.period); gl = b2.lockup;
            end
            default: begin
                gq = b3.q; go = b3.out; gw = b3.wrap;
                gp = b3.period; gl = b3.lockup;
            end
        endcase
    endtask

    task automatic set_in(input int a, input bit e, input bit l,
                          input logic [15:0] s);
        b0.en = (a == 0) && e; b0.load = (a == 0) && l; b0.seed_in = s[2:0];
        b1.en = (a == 1) && e; b1.load = (a == 1) && l; b1.seed_in = s[4:0];
        b2.en = (a == 2) && e; b2.load = (a == 2) && l; b2.seed_in = s[7:0];
        b3.en = (a == 3) && e; b3.load = (a == 3) && l; b3.seed_in = s;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mq[i] = wmask(i); msr[i] = wmask(i);
            mcnt[i] = '0; mper[i] = '0;
            mout[i] = 1'b1; mwrap[i] = 1'b0; mlk[i] = 1'b0;
        end
    endtask

    task automatic model_cycle(input int a, input bit e, input bit l,
                               input logic [15:0] s);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] m, v, nq;
            m = wmask(i);
            mwrap[i] = 1'b0;
            mlk[i] = 1'b0;
            if (i == a && l) begin
                v = s & m;
`ifdef LFSR_LOCKUP_RECOVER_EN
                if (v == '0) begin
                    v = m;
                    mlk[i] = 1'b1;
                end
`endif
                mout[i] = mq[i][0];
                mq[i] = v; msr[i] = v; mcnt[i] = '0;
            end else if (i == a && e) begin
                nq = ((mq[i] >> 1) |
                      ({15'b0, ^(mq[i] & MSK[i])} << (W[i] - 1))) & m;
                mout[i] = mq[i][0];
                if (nq == msr[i]) begin
                    mwrap[i] = 1'b1;
                    mper[i] = (mcnt[i] + 16'd1) & m;
                    mcnt[i] = '0;
                end else begin
                    mcnt[i] = (mcnt[i] + 16'd1) & m;
                end
                mq[i] = nq;
            end
        end
    endtask

    task automatic drive(input int a, input bit e, input bit l,
                         input logic [15:0] s, input string tag);
        exp_t x;
        set_in(a, e, l, s);
        model_cycle(a, e, l, s);
        x.inst = a; x.q = mq[a]; x.out = mout[a]; x.wrap = mwrap[a];
        x.period = mper[a]; x.lockup = mlk[a]; x.tag = tag;
        sbq.push_back(x);
        @(negedge clk);
    endtask

    task automatic drive_hand(input int a, input bit e, input bit l,
                              input logic [15:0] s, input logic [15:0] hq,
                              input logic ho, input logic hw,
                              input logic [15:0] hp, input logic hl,
                              input string tag);
        exp_t x;
        set_in(a, e, l, s);
        model_cycle(a, e, l, s);
        x.inst = a; x.q = hq; x.out = ho; x.wrap = hw;
        x.period = hp; x.lockup = hl; x.tag = tag;
        sbq.push_back(x);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] want);
        nvec++;
        if (got !== want) begin
            nbad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            exp_t x;
            logic [15:0] gq, gp;
            logic go, gw, gl;
            x = sbq.pop_front();
            get(x.inst, gq, go, gw, gp, gl);
            nvec++;
            if (gq !== x.q || go !== x.out || gw !== x.wrap ||
                gp !== x.period || gl !== x.lockup) begin
                nbad++;
                $display("FAIL %s inst%0d: got q=%h out=%b wrap=%b per=%h lk=%b want q=%h out=%b wrap=%b per=%h lk=%b",
                         x.tag, x.inst, gq, go, gw, gp, gl,
                         x.q, x.out, x.wrap, x.period, x.lockup);
            end
        end
    end

    logic [15:0] h3q[7] = '{16'h3, 16'h1, 16'h4, 16'h2, 16'h5, 16'h6, 16'h7};
    logic        h3o[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        logic [15:0] gq, gp;
        logic go, gw, gl;
        int steps, budget;

        reset_n = 1'b0;
        set_in(0, 1'b0, 1'b0, 16'h0);
        model_reset();
        #12;
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            get(i, gq, go, gw, gp, gl);
            chk($sformatf("rst_q%0d", i), gq, wmask(i));
            chk($sformatf("rst_out%0d", i), 16'(go), 16'h1);
            chk($sformatf("rst_wrap%0d", i), 16'(gw), 16'h0);
            chk($sformatf("rst_per%0d", i), gp, 16'h0);
            chk($sformatf("rst_lk%0d", i), 16'(gl), 16'h0);
        end

        for (int k = 0; k < 7; k++)
            drive_hand(0, 1'b1, 1'b0, 16'h0, h3q[k], h3o[k], k == 6,
                       (k == 6) ? 16'd7 : 16'd0, 1'b0, "w3_seq");
        drive_hand(0, 1'b0, 1'b0, 16'h0, 16'h7, 1'b0, 1'b0, 16'd7, 1'b0,
                   "w3_hold");

`ifdef LFSR_LOCKUP_RECOVER_EN
        drive_hand(0, 1'b1, 1'b1, 16'h0, 16'h7, 1'b1, 1'b0, 16'd7, 1'b1,
                   "w3_zero_load");
        drive_hand(0, 1'b1, 1'b0, 16'h0, 16'h3, 1'b1, 1'b0, 16'd7, 1'b0,
                   "w3_zero_step");
        drive_hand(0, 1'b1, 1'b0, 16'h0, 16'h1, 1'b1, 1'b0, 16'd7, 1'b0,
                   "w3_zero_step");
        drive_hand(0, 1'b1, 1'b0, 16'h0, 16'h4, 1'b1, 1'b0, 16'd7, 1'b0,
                   "w3_zero_step");
`else
        drive_hand(0, 1'b1, 1'b1, 16'h0, 16'h0, 1'b1, 1'b0, 16'd7, 1'b0,
                   "w3_zero_load");
        for (int k = 0; k < 3; k++)
            drive_hand(0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'd1, 1'b0,
                       "w3_zero_step");
`endif
        drive(0, 1'b0, 1'b0, 16'h0, "w3_idle");

        for (int k = 0; k < 255; k++)
            drive(2, 1'b1, 1'b0, 16'h0, "w8_run");
        for (int k = 0; k < 20; k++)
            drive(2, 1'b1, 1'b0, 16'h0, "w8_pre");
        drive_hand(2, 1'b1, 1'b1, 16'hA5, 16'hA5, mq[2][0], 1'b0, 16'd255,
                   1'b0, "w8_load_a5");
        for (int k = 0; k < 255; k++)
            drive(2, 1'b1, 1'b0, 16'h0, "w8_reload");
        drive(2, 1'b0, 1'b0, 16'h0, "w8_hold");
        drive(2, 1'b0, 1'b0, 16'h0, "w8_hold");

        steps = 0;
        budget = 0;
        while (steps < 40 && budget < 1000) begin
            bit e;
            e = ($urandom_range(0, 2) != 0);
            if (e) steps++;
            budget++;
            drive(1, e, 1'b0, 16'h0, "w5_rand");
        end
        drive(1, 1'b0, 1'b0, 16'h0, "w5_idle");
        @(posedge clk);
        #3;
        get(1, gq, go, gw, gp, gl);
        chk("w5_period", gp, 16'd31);
        @(negedge clk);

        for (int k = 0; k < 65535; k++)
            drive(3, 1'b1, 1'b0, 16'h0, "w16_run");
        #2;
        get(3, gq, go, gw, gp, gl);
        chk("w16_wrap_pre", 16'(gw), 16'h1);
        chk("w16_period", gp, 16'hFFFF);
        get(2, gq, go, gw, gp, gl);
        chk("w8_period", gp, 16'd255);

        reset_n = 1'b0;
        #1;
        get(3, gq, go, gw, gp, gl);
        chk("arst_q16", gq, 16'hFFFF);
        chk("arst_out16", 16'(go), 16'h1);
        chk("arst_wrap16", 16'(gw), 16'h0);
        chk("arst_per16", gp, 16'h0);
        get(2, gq, go, gw, gp, gl);
        chk("arst_q8", gq, 16'h00FF);
        chk("arst_per8", gp, 16'h0);
        set_in(0, 1'b0, 1'b0, 16'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        drive_hand(0, 1'b1, 1'b0, 16'h0, 16'h3, 1'b1, 1'b0, 16'd0, 1'b0,
                   "w3_restart");
        drive_hand(0, 1'b1, 1'b0, 16'h0, 16'h1, 1'b1, 1'b0, 16'd0, 1'b0,
                   "w3_restart");
        set_in(0, 1'b0, 1'b0, 16'h0);

        @(posedge clk);
        #3;
        nvec++;
        if (sbq.size() != 0) begin
            nbad++;
            $display("FAIL drain: got %0d pending want 0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci LFSR pseudo-random generator with a built-in maximal-length tap table for widths 3–16, run-time seed load, a step enable, and period-wrap detection with a measured-period register. It is the generalised successor of the team's fixed 3-bit LFSR. It feeds test-pattern, scrambler and noise consumers that need a one-bit serial stream and/or the full parallel state.

## Interface
- `WIDTH`, 8: state width; legal range 3..16 (elaboration error otherwise).
- `SEED`, all ones: reset and recovery seed; must be nonzero (elaboration error if 0).
- `TAPS`, 0: feedback tap mask; 0 selects the built-in table; nonzero overrides it and must have bit 0 set.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  advance the LFSR one step this cycle.
- `load`  in  1  load `seed_in` this cycle; has priority over `en`.
- `seed_in`  in  WIDTH  seed value for `load`.
- `out`  out  1  registered serial output; the previous cycle's `q[0]`.
- `q`  out  WIDTH  current LFSR state.
- `wrap`  out  1  one-cycle pulse when the state returns to the active seed.
- `period`  out  WIDTH  step count of the last completed cycle.
- `lockup`  out  1  one-cycle pulse when a zero seed was corrected (macro builds only).

## Operation
- **Step.** Feedback `fb` = XOR over `q[i]` where `mask[i]`=1. The next state is `{fb, q[WIDTH-1:1]}`, i.e. shift right and insert at the MSB. The recurrence is s(t+W) = Σ mask[i]·s(t+i).
- **Built-in masks** (the polynomial is x^W + Σ mask bits):
  - W3 3'h3, W4 4'h3, W5 5'h05, W6 6'h03, W7 7'h03, W8 8'h1D.
  - W9 9'h011, W10 10'h009, W11 11'h005, W12 12'h053, W13 13'h001B.
  - W14 14'h0443, W15 15'h0003, W16 16'h100B.
  - All masks are maximal: period 2^W−1.
- **Active seed register `sreg`.** Holds the last accepted seed: `SEED` after reset, otherwise the value accepted by `load`.
- **Step counter `cnt`** (WIDTH bits):
  - Cleared on reset and on load.
  - Otherwise increments on each `en` step.
  - When a step produces next state == `sreg`: pulse `wrap` on the following cycle, copy cnt+1 (mod 2^WIDTH) into `period`, and clear `cnt`.
  - For maximal taps, `period` reads 2^W−1.
- **Per-cycle priority:**
  - `load`: q←seed_in (zero seed handling is in Configuration), sreg←same value, cnt←0, `out`←q[0], `wrap`←0.
  - else `en`: perform a step; `out`←q[0] (the pre-step value).
  - else: hold q, cnt and `out`; `wrap`←0.
- **`lockup`.** Low except on the cycle after a corrected zero load.

## Timing
- **Reset values:** q=SEED, sreg=SEED, out=1, cnt=0, period=0, wrap=0, lockup=0.
- **Reset mid-operation:** immediate asynchronous return to the reset values.
- **Latency:**
  - `q` updates on the edge where `en` or `load` is sampled.
  - `out` lags `q[0]` by one enabled step.
  - `wrap` and `lockup` are registered and appear in the cycle after the triggering edge, aligned with the new `q`.
- **Simultaneous `load` and `en`:** load wins; no step occurs and cnt=0.
- **`en` held low:** all state frozen; a pending `wrap` is not regenerated.
- **Counter overflow:** for TAPS overrides with a period above 2^W−1 (impossible) or non-maximal masks, `cnt` wraps modulo 2^W without error. `period` reports the true period for any period ≤ 2^W−1.
- **Zero state:** unreachable by stepping from a nonzero state.

## Configuration
- **Macro `LFSR_LOCKUP_RECOVER_EN`:**
  - **Defined:** a `load` with seed_in==0 loads `SEED` into both q and sreg, and pulses `lockup` for one cycle.
  - **Undefined:** a zero seed is loaded as-is and the LFSR stays at 0 forever. Each step still increments cnt, and `wrap` pulses every step with period=1. `lockup` is tied to 0.

## Test plan
- **Reset, WIDTH=3, SEED=3'b111, en=1:**
  - q must be 111, 011, 001, 100, 010, 101, 110, 111.
  - out must be 1, 1, 1, 1, 0, 0, 1, 0 on successive cycles.
  - wrap must pulse with q=111 and period=7.
- **WIDTH=8 free-running from reset:** wrap first pulses exactly 255 steps after reset, period=255, and no state repeats before it. Repeat for WIDTH=16: period=65535.
- **Load and en together, seed_in=8'hA5 mid-sequence:** the next q=8'hA5, cnt restarts, and the next wrap comes 255 steps later with q=8'hA5.
- **en toggled randomly (WIDTH=5):** the state sequence must equal the en=1 reference sequence with holds inserted; period must still be 31.
- **Load seed_in=0:**
  - With the macro: q=SEED and lockup=1 for one cycle.
  - Without the macro: q stays 0 and wrap pulses every enabled cycle with period=1.
- **Assert reset_n low between clock edges mid-sequence:** q=SEED, out=1, period=0 and wrap=0 immediately, without waiting for a clock edge.
